// File: rtl/fpga_clkseq_pkg.sv
// Shared constants for the PLL clock/reset sequencer: FSM encoding,
// state width, channel limit and a counter-width helper.
package fpga_clkseq_pkg;

  localparam int unsigned SEQ_STATE_W = 2;
  localparam int unsigned MAX_NUM_CH  = 16;

  localparam logic [SEQ_STATE_W-1:0] PLL_RST   = 2'd0;
  localparam logic [SEQ_STATE_W-1:0] WAIT_LOCK = 2'd1;
  localparam logic [SEQ_STATE_W-1:0] RELEASE   = 2'd2;
  localparam logic [SEQ_STATE_W-1:0] RUN       = 2'd3;

  // Width able to hold 0..v-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fpga_clk_rst_seq_if.sv
// Bundle of PLL-side and channel-side signals of the clock/reset sequencer.
interface fpga_clk_rst_seq_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8
);
  import fpga_clkseq_pkg::*;

  logic                      pll_locked;
  logic [NUM_CH*DIV_W-1:0]   div_ratio;
  logic                      pll_areset;
  logic [NUM_CH-1:0]         ch_rst_n;
  logic [NUM_CH-1:0]         ch_clk_en;
  logic                      sys_ready;
  logic [SEQ_STATE_W-1:0]    seq_state;

  modport master (
    input  pll_locked, div_ratio,
    output pll_areset, ch_rst_n, ch_clk_en, sys_ready, seq_state
  );

  modport slave (
    output pll_locked, div_ratio,
    input  pll_areset, ch_rst_n, ch_clk_en, sys_ready, seq_state
  );

endinterface

// File: rtl/fpga_clk_en_div.sv
// Per-channel clock-enable divider. ch_rst_n is the channel reset level
// that takes effect on this edge, so the enable drops together with it.
module fpga_clk_en_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             ch_rst_n,
  input  logic [DIV_W-1:0] ratio,
  output logic             ch_clk_en
);

  logic [DIV_W-1:0] cnt;
  logic             run_q;

  // Divide counter; the release edge itself only arms the counter
  always_ff @(posedge clk_in) begin
    if (!reset_n || !ch_rst_n) begin
      cnt       <= '0;
      run_q     <= 1'b0;
      ch_clk_en <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (ratio < DIV_W'(2)) begin
        cnt       <= '0;
        ch_clk_en <= 1'b1;
      end else if (!run_q) begin
        cnt       <= '0;
        ch_clk_en <= 1'b0;
      end else if (cnt >= ratio - DIV_W'(1)) begin
        cnt       <= '0;
        ch_clk_en <= 1'b1;
      end else begin
        cnt       <= cnt + DIV_W'(1);
        ch_clk_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fpga_clk_rst_seq.sv
// PLL lock qualifier, PLL re-reset on lock timeout, staggered per-channel
// reset release and per-channel divided clock enables.
// Optional lock-loss event counter: define FPGA_CLKSEQ_LOSS_CNT_EN.
module fpga_clk_rst_seq
  import fpga_clkseq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned LOCK_CNT    = 1024,
  parameter int unsigned RST_STAGGER = 16,
  parameter int unsigned TIMEOUT     = 65536,
  parameter int unsigned PLL_RST_CYC = 32
) (
  input  logic               clk_in,
  input  logic               reset_n,
  fpga_clk_rst_seq_if.master bus
`ifdef FPGA_CLKSEQ_LOSS_CNT_EN
  ,
  output logic [15:0]        lock_loss_cnt
`endif
);

  localparam int unsigned PRST_W  = cnt_w(PLL_RST_CYC);
  localparam int unsigned LOCK_W  = cnt_w(LOCK_CNT);
  localparam int unsigned TO_W    = cnt_w(TIMEOUT);
  localparam int unsigned STG_MAX = NUM_CH * RST_STAGGER;
  localparam int unsigned STG_W   = cnt_w(STG_MAX + 1);

  localparam logic [PRST_W-1:0] PRST_LAST = PRST_W'(PLL_RST_CYC - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CNT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STG_MAX);

  logic                    sync1, lock_s;
  logic [SEQ_STATE_W-1:0]  state, state_nxt;
  logic [PRST_W-1:0]       prst_cnt, prst_cnt_nxt;
  logic [LOCK_W-1:0]       stable_cnt, stable_cnt_nxt;
  logic [TO_W-1:0]         to_cnt, to_cnt_nxt;
  logic [STG_W-1:0]        stg_cnt, stg_cnt_nxt;
  logic [NUM_CH-1:0]       rst_n_q, rst_n_nxt;
  logic [NUM_CH*DIV_W-1:0] shadow, shadow_nxt;
  logic                    pll_areset_q, sys_ready_q;
  logic [NUM_CH-1:0]       clk_en;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.pll_locked;
      lock_s <= sync1;
    end
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state        <= PLL_RST;
      prst_cnt     <= '0;
      stable_cnt   <= '0;
      to_cnt       <= '0;
      stg_cnt      <= '0;
      rst_n_q      <= '0;
      shadow       <= '0;
      pll_areset_q <= 1'b1;
      sys_ready_q  <= 1'b0;
    end else begin
      state        <= state_nxt;
      prst_cnt     <= prst_cnt_nxt;
      stable_cnt   <= stable_cnt_nxt;
      to_cnt       <= to_cnt_nxt;
      stg_cnt      <= stg_cnt_nxt;
      rst_n_q      <= rst_n_nxt;
      shadow       <= shadow_nxt;
      pll_areset_q <= (state_nxt == PLL_RST);
      sys_ready_q  <= (state_nxt == RUN);
    end
  end

  // Next-state and counter logic; counters are zero outside their own state
  always_comb begin
    state_nxt      = state;
    prst_cnt_nxt   = '0;
    stable_cnt_nxt = '0;
    to_cnt_nxt     = '0;
    stg_cnt_nxt    = '0;
    rst_n_nxt      = '0;
    shadow_nxt     = shadow;
    case (state)
      PLL_RST: begin
        if (prst_cnt >= PRST_LAST) state_nxt = WAIT_LOCK;
        else                       prst_cnt_nxt = prst_cnt + PRST_W'(1);
      end
      WAIT_LOCK: begin
        if (lock_s)
          stable_cnt_nxt = (stable_cnt >= LOCK_LAST) ? stable_cnt : stable_cnt + LOCK_W'(1);
        to_cnt_nxt = (to_cnt >= TO_LAST) ? to_cnt : to_cnt + TO_W'(1);
        // Lock qualification takes priority over a coincident timeout
        if (lock_s && stable_cnt >= LOCK_LAST) begin
          state_nxt      = RELEASE;
          shadow_nxt     = bus.div_ratio;
          stable_cnt_nxt = '0;
          to_cnt_nxt     = '0;
        end else if (to_cnt >= TO_LAST) begin
          state_nxt      = PLL_RST;
          stable_cnt_nxt = '0;
          to_cnt_nxt     = '0;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else begin
          stg_cnt_nxt = (stg_cnt >= STG_LAST) ? stg_cnt : stg_cnt + STG_W'(1);
          for (int i = 0; i < NUM_CH; i++)
            rst_n_nxt[i] = rst_n_q[i] | (stg_cnt_nxt >= STG_W'((i + 1) * RST_STAGGER));
          if (rst_n_q[NUM_CH-1]) state_nxt = RUN;
        end
      end
      RUN: begin
        if (!lock_s) state_nxt = WAIT_LOCK;
        else         rst_n_nxt = rst_n_q;
      end
      default: state_nxt = PLL_RST;
    endcase
  end

  // One enable divider per channel, fed from the latched ratios
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fpga_clk_en_div #(.DIV_W(DIV_W)) u_div (
      .clk_in    (clk_in),
      .reset_n   (reset_n),
      .ch_rst_n  (rst_n_nxt[g]),
      .ratio     (shadow[g*DIV_W +: DIV_W]),
      .ch_clk_en (clk_en[g])
    );
  end

`ifdef FPGA_CLKSEQ_LOSS_CNT_EN
  logic loss_evt;

  // Lock-loss exit from RELEASE/RUN or a WAIT_LOCK timeout
  always_comb begin
    loss_evt = ((state == RELEASE || state == RUN) && state_nxt == WAIT_LOCK) ||
               (state == WAIT_LOCK && state_nxt == PLL_RST);
  end

  // Saturating lock-loss event counter, cleared only by reset_n
  always_ff @(posedge clk_in) begin
    if (!reset_n)                                lock_loss_cnt <= '0;
    else if (loss_evt && lock_loss_cnt != 16'hFFFF) lock_loss_cnt <= lock_loss_cnt + 16'd1;
  end
`endif

  assign bus.pll_areset = pll_areset_q;
  assign bus.ch_rst_n   = rst_n_q;
  assign bus.ch_clk_en  = clk_en;
  assign bus.sys_ready  = sys_ready_q;
  assign bus.seq_state  = state;

endmodule

// File: tb/tb_fpga_clk_rst_seq.sv
// Directed bench for fpga_clk_rst_seq: expected per-cycle observations are
// queued with each stimulus step and retired by a negedge monitor.
module tb_fpga_clk_rst_seq;
  import fpga_clkseq_pkg::*;

  localparam int F_AR = 0;
  localparam int F_RN = 1;
  localparam int F_EN = 2;
  localparam int F_RDY = 3;
  localparam int F_ST = 4;
  localparam int F_LC = 5;

  typedef struct {
    int          cyc;
    int          fld;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic        clk_in = 1'b0;
  logic        reset_n;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mon_obs;

  fpga_clk_rst_seq_if #(.NUM_CH(2), .DIV_W(8)) bus ();

`ifdef FPGA_CLKSEQ_LOSS_CNT_EN
  logic [15:0] lock_loss_cnt;
`endif

  fpga_clk_rst_seq #(
    .NUM_CH(2), .DIV_W(8), .LOCK_CNT(8), .RST_STAGGER(4),
    .TIMEOUT(64), .PLL_RST_CYC(4)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FPGA_CLKSEQ_LOSS_CNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [15:0] observe(input int f);
    case (f)
      F_AR:  return 16'(bus.pll_areset);
      F_RN:  return 16'(bus.ch_rst_n);
      F_EN:  return 16'(bus.ch_clk_en);
      F_RDY: return 16'(bus.sys_ready);
      F_ST:  return 16'(bus.seq_state);
`ifdef FPGA_CLKSEQ_LOSS_CNT_EN
      F_LC:  return lock_loss_cnt;
`endif
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic exp_at(input int c, input int f, input logic [15:0] v, input string tag);
    exp_t e;
    e.cyc = c; e.fld = f; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp_all(input int c, input logic [15:0] st, input logic [15:0] ar,
                         input logic [15:0] rn, input logic [15:0] en,
                         input logic [15:0] rdy, input string tag);
    exp_at(c, F_ST, st, {tag, "_state"});
    exp_at(c, F_AR, ar, {tag, "_areset"});
    exp_at(c, F_RN, rn, {tag, "_rst_n"});
    exp_at(c, F_EN, en, {tag, "_clk_en"});
    exp_at(c, F_RDY, rdy, {tag, "_ready"});
  endtask

  task automatic go_after(input int n);
    wait (cyc >= n);
    #1;
  endtask

  // Retire every expectation due at this cycle
  always @(negedge clk_in) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        mon_obs = observe(sb[i].fld);
        assert (mon_obs === sb[i].val) else begin
          errors++;
          $error("FAIL %s @cyc %0d: observed %0h expected %0h", sb[i].tag, cyc, mon_obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    bus.pll_locked = 1'b1;
    bus.div_ratio  = {8'd1, 8'd3};

    // Power-up: release at 15, channels at 19/23, RUN at 24
    exp_all(3, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, "reset");
    for (int c = 4; c <= 6; c++) exp_at(c, F_AR, 16'd1, "prst_hold");
    exp_at(6, F_ST, 16'd0, "prst_state");
    exp_at(7, F_AR, 16'd0, "prst_end");
    exp_at(7, F_ST, 16'd1, "enter_wait");
    exp_at(14, F_ST, 16'd1, "still_wait");
    exp_at(15, F_ST, 16'd2, "enter_release");
    exp_at(18, F_RN, 16'd0, "ch0_pre");
    exp_at(19, F_RN, 16'd1, "ch0_rise");
    exp_at(22, F_RN, 16'd1, "ch1_pre");
    exp_at(23, F_RN, 16'd3, "ch1_rise");
    exp_at(23, F_RDY, 16'd0, "ready_pre");
    exp_at(24, F_RDY, 16'd1, "ready");
    exp_at(24, F_ST, 16'd3, "enter_run");
    for (int c = 19; c <= 21; c++) exp_at(c, F_EN, 16'd0, "en_wait");
    exp_at(22, F_EN, 16'd1, "en0_first");
    exp_at(23, F_EN, 16'd2, "en1_on");
    exp_at(24, F_EN, 16'd2, "en_gap");
    exp_at(25, F_EN, 16'd3, "en0_second");
    exp_at(26, F_EN, 16'd2, "en_gap2");
    exp_at(27, F_EN, 16'd2, "en_gap3");
    exp_at(28, F_EN, 16'd3, "en0_third");
`ifdef FPGA_CLKSEQ_LOSS_CNT_EN
    exp_at(3, F_LC, 16'd0, "lc_reset");
`endif
    go_after(3);
    reset_n = 1'b1;

    // New ratios must not disturb the running channels
    go_after(26);
    bus.div_ratio = {8'd2, 8'd5};

    // Loss in RUN, then relock with the new ratios latched
    go_after(30);
    exp_at(32, F_ST, 16'd3, "run_pre_loss");
    exp_at(32, F_RN, 16'd3, "rst_pre_loss");
    exp_all(33, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, "loss_run");
    exp_at(44, F_ST, 16'd1, "relock_wait");
    exp_at(45, F_ST, 16'd2, "relock_release");
    exp_at(48, F_RN, 16'd0, "re_ch0_pre");
    exp_at(49, F_RN, 16'd1, "re_ch0_rise");
    exp_at(52, F_RN, 16'd1, "re_ch1_pre");
    exp_at(53, F_RN, 16'd3, "re_ch1_rise");
    exp_at(53, F_RDY, 16'd0, "re_ready_pre");
    exp_at(54, F_RDY, 16'd1, "re_ready");
    exp_at(54, F_ST, 16'd3, "re_run");
    exp_at(51, F_EN, 16'd0, "sh_en_51");
    exp_at(52, F_EN, 16'd0, "sh_en_52");
    exp_at(53, F_EN, 16'd0, "sh_en_53");
    exp_at(54, F_EN, 16'd1, "sh_en_54");
    exp_at(55, F_EN, 16'd2, "sh_en_55");
    exp_at(56, F_EN, 16'd0, "sh_en_56");
    exp_at(57, F_EN, 16'd2, "sh_en_57");
    exp_at(58, F_EN, 16'd0, "sh_en_58");
    exp_at(59, F_EN, 16'd3, "sh_en_59");
`ifdef FPGA_CLKSEQ_LOSS_CNT_EN
    exp_at(32, F_LC, 16'd0, "lc_pre_loss");
    exp_at(33, F_LC, 16'd1, "lc_loss1");
`endif
    bus.pll_locked = 1'b0;
    go_after(35);
    bus.pll_locked = 1'b1;

    // Second loss, relock, then reset pulse during RELEASE
    go_after(60);
    exp_at(62, F_ST, 16'd3, "run2_pre_loss");
    exp_all(63, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, "loss_run2");
    exp_at(74, F_ST, 16'd1, "relock2_wait");
    exp_at(75, F_ST, 16'd2, "relock2_release");
    exp_at(78, F_RN, 16'd0, "r2_ch0_pre");
    exp_at(79, F_RN, 16'd1, "r2_ch0_rise");
    exp_at(80, F_ST, 16'd2, "pre_reset_state");
    exp_all(81, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, "midseq_reset");
    exp_at(84, F_AR, 16'd1, "rs_prst_hold");
    exp_at(84, F_ST, 16'd0, "rs_prst_state");
    exp_at(85, F_AR, 16'd0, "rs_prst_end");
    exp_at(85, F_ST, 16'd1, "rs_wait");
    exp_at(92, F_ST, 16'd1, "rs_still_wait");
    exp_at(93, F_ST, 16'd2, "rs_release");
    exp_at(97, F_RN, 16'd1, "rs_ch0_rise");
    exp_at(101, F_RN, 16'd3, "rs_ch1_rise");
    exp_at(102, F_ST, 16'd3, "rs_run");
    exp_at(102, F_RDY, 16'd1, "rs_ready");
`ifdef FPGA_CLKSEQ_LOSS_CNT_EN
    exp_at(63, F_LC, 16'd2, "lc_loss2");
    exp_at(80, F_LC, 16'd2, "lc_pre_reset");
    exp_at(81, F_LC, 16'd0, "lc_cleared");
`endif
    bus.pll_locked = 1'b0;
    go_after(65);
    bus.pll_locked = 1'b1;
    go_after(80);
    reset_n = 1'b0;
    go_after(81);
    reset_n = 1'b1;

    // Glitching lock: loss from RUN, no qualification, timeout re-reset
    go_after(105);
    exp_at(107, F_ST, 16'd3, "gl_run");
    exp_all(108, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, "gl_loss");
    for (int c = 112; c <= 168; c += 8) exp_at(c, F_ST, 16'd1, "gl_no_release");
    exp_at(171, F_ST, 16'd1, "gl_pre_timeout");
    exp_at(171, F_AR, 16'd0, "gl_pre_timeout_ar");
    exp_at(172, F_ST, 16'd0, "gl_timeout");
    exp_at(172, F_AR, 16'd1, "gl_timeout_ar");
    exp_at(175, F_AR, 16'd1, "gl_prst_hold");
    exp_at(176, F_AR, 16'd0, "gl_prst_end");
    exp_at(176, F_ST, 16'd1, "gl_wait");
    exp_at(185, F_ST, 16'd1, "gl_relock_wait");
    exp_at(186, F_ST, 16'd2, "gl_release");
    exp_at(189, F_RN, 16'd0, "gl_ch0_pre");
    exp_at(190, F_RN, 16'd1, "gl_ch0_rise");
`ifdef FPGA_CLKSEQ_LOSS_CNT_EN
    exp_at(107, F_LC, 16'd0, "lc_pre_gl");
    exp_at(108, F_LC, 16'd1, "lc_gl_loss");
    exp_at(171, F_LC, 16'd1, "lc_pre_timeout");
    exp_at(172, F_LC, 16'd2, "lc_timeout");
`endif
    for (int j = 0; j < 15; j++) begin
      go_after(105 + 5 * j);
      bus.pll_locked = 1'b0;
      go_after(106 + 5 * j);
      bus.pll_locked = 1'b1;
    end

    go_after(195);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_clk_rst_seq.md
Name: fpga_clk_rst_seq

Overview:
- Parametrised successor to the single-output PLL wrapper. Sits beside the PLL and runs on the PLL output clock.
- Qualifies the PLL lock and re-resets the PLL when lock times out.
- Releases per-channel synchronous resets in a staggered sequence.
- Generates per-channel divided clock-enable pulses, so one PLL clock serves NUM_CH logical clock domains.

Parameters:
- NUM_CH, 4: number of output channels (1..16).
- DIV_W, 8: width of each channel divide ratio.
- LOCK_CNT, 1024: consecutive synchronised lock cycles required before release.
- RST_STAGGER, 16: cycles between successive channel reset releases.
- TIMEOUT, 65536: cycles in WAIT_LOCK without qualified lock before the PLL is re-reset.
- PLL_RST_CYC, 32: length of the pll_areset pulse, in cycles.

Ports:
- clk_in, input, 1: clock (PLL output clock).
- reset_n, input, 1: synchronous, active-low reset.
- pll_locked, input, 1: raw PLL lock, asynchronous to clk_in.
- div_ratio, input, NUM_CH*DIV_W: per-channel divide ratio. Channel i occupies bits [i*DIV_W +: DIV_W].
- pll_areset, output, 1: active-high reset request to the PLL.
- ch_rst_n, output, NUM_CH: per-channel synchronous active-low reset.
- ch_clk_en, output, NUM_CH: per-channel clock-enable pulse.
- sys_ready, output, 1: all channels released and running.
- seq_state, output, 2: current FSM state encoding.

Behaviour:
- Reset values (reset_n=0, sampled on clk_in rise):
  - State PLL_RST; pll_areset=1; ch_rst_n=0; ch_clk_en=0; sys_ready=0.
  - Synchroniser flops and all counters = 0.
- Lock synchroniser: 2-flop sync of pll_locked gives lock_s. Latency is 2 cycles.
- All outputs are registered.
- FSM encoding: PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
- PLL_RST:
  - pll_areset=1 for exactly PLL_RST_CYC cycles, then go to WAIT_LOCK.
  - lock_s is ignored in this state.
- WAIT_LOCK:
  - pll_areset=0.
  - stable_cnt increments while lock_s=1 and clears to 0 on any lock_s=0.
  - When stable_cnt reaches LOCK_CNT-1 with lock_s=1: go to RELEASE and latch div_ratio into per-channel shadow registers.
  - to_cnt increments every cycle in this state. When it reaches TIMEOUT-1: go to PLL_RST.
  - If both conditions occur in the same cycle, lock qualification wins.
  - to_cnt clears on state entry.
- RELEASE:
  - Channel i's ch_rst_n rises at exactly (i+1)*RST_STAGGER cycles after RELEASE entry.
  - Once channel NUM_CH-1 is released, go to RUN the next cycle; sys_ready=1 from RUN entry.
- RUN: hold all outputs until lock loss.
- Lock loss in RELEASE or RUN (lock_s=0):
  - Next cycle: all ch_rst_n=0, all ch_clk_en=0, sys_ready=0, state WAIT_LOCK.
  - No PLL reset on loss; only a WAIT_LOCK timeout re-resets the PLL.
- Clock enables:
  - Per-channel counter, held at 0 while that channel's ch_rst_n=0.
  - Shadow ratio N>=2: ch_clk_en pulses for 1 cycle when counter==N-1; counter wraps to 0. The first pulse is N cycles after the ch_rst_n rise.
  - N=0 or N=1: ch_clk_en=1 continuously while ch_rst_n=1.
  - Changes on div_ratio take effect only at the next RELEASE entry.
- reset_n asserted mid-sequence: returns to PLL_RST on the next edge and restarts the full sequence.
- Counter widths: $clog2 of the parameter, with no overflow. All counters saturate at their terminal value.

Optional Feature:
- Macro: FPGA_CLKSEQ_LOSS_CNT_EN.
- When defined:
  - Adds output port lock_loss_cnt, 16 bits.
  - It increments once per lock-loss exit from RELEASE/RUN and once per WAIT_LOCK timeout.
  - It saturates at 16'hFFFF and is cleared only by reset_n.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package fpga_clkseq_pkg holds:
  - the state encoding constants PLL_RST, WAIT_LOCK, RELEASE, RUN;
  - the seq_state width;
  - the maximum NUM_CH constant.
- One sub-module fpga_clk_en_div, instantiated NUM_CH times:
  - Inputs: clk_in, reset_n, ch_rst_n, shadow ratio.
  - Output: ch_clk_en.
- The top level holds the synchroniser, FSM, stagger and timeout counters.

Test Plan:
All tests use NUM_CH=2, LOCK_CNT=8, RST_STAGGER=4, TIMEOUT=64, PLL_RST_CYC=4.
- Power-up: reset_n low 3 cycles, then high; pll_locked=1 constant.
  - pll_areset high for 4 cycles after reset.
  - ch_rst_n[0] rises 4 cycles after RELEASE entry; ch_rst_n[1] rises 8 cycles after; sys_ready follows 1 cycle later.
- Divide ratios: div_ratio = {8'd1, 8'd3}.
  - ch_clk_en[0] pulses every 3rd cycle, first pulse 3 cycles after ch_rst_n[0] rises.
  - ch_clk_en[1] is constantly 1 after release.
- Lock glitch: pll_locked toggles low for 1 cycle every 5 cycles.
  - stable_cnt never reaches 7; no release.
  - After 64 cycles in WAIT_LOCK: PLL_RST with pll_areset high for 4 cycles.
- Loss in RUN: drop pll_locked in RUN.
  - Within 3 cycles all ch_rst_n=0, ch_clk_en=0, sys_ready=0, seq_state=1.
  - Relock replays the staggered release.
- Mid-sequence reset: pulse reset_n low during RELEASE.
  - All outputs return to reset values next cycle.
  - The sequence restarts from PLL_RST.
- With FPGA_CLKSEQ_LOSS_CNT_EN defined: 2 RUN losses plus 1 timeout give lock_loss_cnt=3.
